// File: rtl/scan_7s_decoder.sv
// -----------------------------------------------------------------------------
// scan_7s_decoder
// Receiving end of a multiplexed 7-segment scan bus. The scanned segment lines
// and the digit-select lines are registered once. A pattern that stays stable
// for SETTLE_CYC cycles on a legal select is decoded into the selected BCD
// digit register. The block also flags complete frames, stale digits and
// illegal segment patterns.
//
// Parameters
//   SETTLE_CYC   cycles {seg_in,bas_in} must be stable before capture (>=2)
//   TIMEOUT_CYC  cycles without a refresh before a digit's stale bit sets
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high
//   seg_in[6:0]  segments {a,b,c,d,e,f,g}, active-low
//   bas_in[2:0]  digit select, active-low one-hot
//                (110 unidad, 101 decena, 011 centena)
//   centena/decena/unidad[3:0]  recovered digits, 4'hF = blank
//   frame_valid  1-cycle pulse once all three digits have been captured
//   seg_err      1-cycle pulse when a settled pattern is not a digit or blank
//   stale[2:0]   {centena,decena,unidad} not refreshed within TIMEOUT_CYC
//
// Optional feature (macro SEG_CONFIRM_EN):
//   When defined, a digit register is written only if two consecutive captures
//   for that select decode to the same value. A mismatching capture updates
//   only the per-digit candidate. It sets no mask bit and clears no stale bit.
// -----------------------------------------------------------------------------
module scan_7s_decoder #(
    parameter int SETTLE_CYC  = 16,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic [2:0] bas_in,
    output logic [3:0] centena,
    output logic [3:0] decena,
    output logic [3:0] unidad,
    output logic       frame_valid,
    output logic       seg_err,
    output logic [2:0] stale
);
    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Returns {legal, digit}. Blank (all segments dark) is legal and maps to 4'hF.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'b0000001: r = 5'b1_0000;
            7'b1001111: r = 5'b1_0001;
            7'b0010010: r = 5'b1_0010;
            7'b0000110: r = 5'b1_0011;
            7'b1001100: r = 5'b1_0100;
            7'b0100100: r = 5'b1_0101;
            7'b0100000: r = 5'b1_0110;
            7'b0001111: r = 5'b1_0111;
            7'b0000000: r = 5'b1_1000;
            7'b0000100: r = 5'b1_1001;
            7'b1111111: r = 5'b1_1111;
            default:    r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Digit select as an active-high one-hot {centena,decena,unidad}.
    // 000 means the select is not legal (idle or more than one line low).
    function automatic logic [2:0] bas_onehot(input logic [2:0] bas);
        logic [2:0] r;
        case (bas)
            3'b110:  r = 3'b001;
            3'b101:  r = 3'b010;
            3'b011:  r = 3'b100;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    logic [6:0]          seg_q, seg_d;
    logic [2:0]          bas_q, bas_d;
    state_t              state_q, state_d;
    logic [SW-1:0]       settle_cnt_q, settle_cnt_d;
    logic [6:0]          snap_seg_q, snap_seg_d;
    logic [2:0]          snap_bas_q, snap_bas_d;
    logic                entry_q, entry_d;
    logic [2:0][3:0]     digit_q, digit_d;
    logic [2:0]          mask_q, mask_d;
    logic                frame_valid_q, frame_valid_d;
    logic                seg_err_q, seg_err_d;
    logic [2:0][TW-1:0]  tcnt_q, tcnt_d;
    logic [2:0]          stale_q, stale_d;
`ifdef SEG_CONFIRM_EN
    logic [2:0][3:0]     cand_q, cand_d;
    logic [2:0]          cand_vld_q, cand_vld_d;
`endif

    logic                in_changed_s;
    logic                bas_legal_s;
    logic [4:0]          dec_s;
    logic [2:0]          sel_s;
    logic                cap_s;
    logic [2:0]          commit_s;

    // Input sampling and change detection against the pattern being settled.
    always_comb begin
        seg_d        = seg_in;
        bas_d        = bas_in;
        bas_legal_s  = (bas_onehot(bas_q) != 3'b000);
        in_changed_s = ({seg_q, bas_q} != {snap_seg_q, snap_bas_q});
    end

    // Settle/capture state machine on the registered scan lines.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        snap_seg_d   = snap_seg_q;
        snap_bas_d   = snap_bas_q;
        entry_d      = 1'b0;
        case (state_q)
            ST_WAIT: begin
                if (bas_legal_s) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = SW'(1);
                    snap_seg_d   = seg_q;
                    snap_bas_d   = bas_q;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_SETTLE: begin
                if (in_changed_s) begin
                    if (bas_legal_s) begin
                        settle_cnt_d = SW'(1);
                        snap_seg_d   = seg_q;
                        snap_bas_d   = bas_q;
                    end else begin
                        state_d      = ST_WAIT;
                        settle_cnt_d = {SW{1'b0}};
                    end
                end else if (settle_cnt_q == SETTLE_MAX) begin
                    state_d = ST_DONE;
                    entry_d = 1'b1;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            ST_DONE: begin
                // The capture was made on entry; hold until the scan moves on.
                if (in_changed_s) begin
                    if (bas_legal_s) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = SW'(1);
                        snap_seg_d   = seg_q;
                        snap_bas_d   = bas_q;
                    end else begin
                        state_d      = ST_WAIT;
                        settle_cnt_d = {SW{1'b0}};
                    end
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d      = ST_WAIT;
                settle_cnt_d = {SW{1'b0}};
            end
        endcase
    end

    // Digit capture, frame mask, error pulse and per-digit staleness.
    always_comb begin
        dec_s     = decode_seg(snap_seg_q);
        sel_s     = bas_onehot(snap_bas_q);
        cap_s     = entry_q && dec_s[4];
        seg_err_d = entry_q && !dec_s[4];
`ifdef SEG_CONFIRM_EN
        cand_d     = cand_q;
        cand_vld_d = cand_vld_q;
        commit_s   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (cap_s && sel_s[i]) begin
                commit_s[i]   = cand_vld_q[i] && (cand_q[i] == dec_s[3:0]);
                cand_d[i]     = dec_s[3:0];
                cand_vld_d[i] = 1'b1;
            end else begin
                commit_s[i] = 1'b0;
            end
        end
`else
        commit_s = cap_s ? sel_s : 3'b000;
`endif
        digit_d = digit_q;
        tcnt_d  = tcnt_q;
        stale_d = stale_q;
        for (int i = 0; i < 3; i++) begin
            if (commit_s[i]) begin
                digit_d[i] = dec_s[3:0];
                tcnt_d[i]  = {TW{1'b0}};
            end else if (tcnt_q[i] == TIMEOUT_MAX) begin
                tcnt_d[i]  = TIMEOUT_MAX;
            end else begin
                tcnt_d[i]  = tcnt_q[i] + TW'(1);
            end
            stale_d[i] = (tcnt_d[i] == TIMEOUT_MAX);
        end
        // A full mask fires the pulse and is cleared in the same cycle.
        frame_valid_d = (mask_q == 3'b111);
        mask_d        = (frame_valid_d ? 3'b000 : mask_q) | commit_s;
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q         <= 7'h7F;
            bas_q         <= 3'h7;
            state_q       <= ST_WAIT;
            settle_cnt_q  <= {SW{1'b0}};
            snap_seg_q    <= 7'h7F;
            snap_bas_q    <= 3'h7;
            entry_q       <= 1'b0;
            digit_q       <= {3{4'h0}};
            mask_q        <= 3'b000;
            frame_valid_q <= 1'b0;
            seg_err_q     <= 1'b0;
            tcnt_q        <= {3{{TW{1'b0}}}};
            stale_q       <= 3'b000;
`ifdef SEG_CONFIRM_EN
            cand_q        <= {3{4'h0}};
            cand_vld_q    <= 3'b000;
`endif
        end else begin
            seg_q         <= seg_d;
            bas_q         <= bas_d;
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            snap_seg_q    <= snap_seg_d;
            snap_bas_q    <= snap_bas_d;
            entry_q       <= entry_d;
            digit_q       <= digit_d;
            mask_q        <= mask_d;
            frame_valid_q <= frame_valid_d;
            seg_err_q     <= seg_err_d;
            tcnt_q        <= tcnt_d;
            stale_q       <= stale_d;
`ifdef SEG_CONFIRM_EN
            cand_q        <= cand_d;
            cand_vld_q    <= cand_vld_d;
`endif
        end
    end

    assign unidad      = digit_q[0];
    assign decena      = digit_q[1];
    assign centena     = digit_q[2];
    assign frame_valid = frame_valid_q;
    assign seg_err     = seg_err_q;
    assign stale       = stale_q;

endmodule
